// File: rtl/instr_encoder_pkg.sv
// instr_encoder_pkg: shared types, opcodes and instruction-format unions for the encoder.
//   bus32_t      - 32-bit instruction word
//   enc_kind_t   - request kinds accepted by instr_encoder
//   instr_fmt_t  - packed union overlaying the U/I/S formats on a raw word
package instr_encoder_pkg;
    typedef logic [31:0] bus32_t;
    typedef enum logic [2:0] {
        ENC_LUI   = 3'd0,
        ENC_AUIPC = 3'd1,
        ENC_ALU_I = 3'd2,
        ENC_LW    = 3'd3,
        ENC_SW    = 3'd4,
        ENC_LI    = 3'd5
    } enc_kind_t;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_ALU_I = 7'b0010011;
    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [2:0] F3_WORD  = 3'b010;
    localparam bus32_t     NOP      = 32'h00000013;
    typedef struct packed {
        logic [19:0] imm;
        logic [4:0]  rd;
        logic [6:0]  opcode;
    } u_fmt_t;
    typedef struct packed {
        logic [11:0] imm;
        logic [4:0]  rs1;
        logic [2:0]  funct3;
        logic [4:0]  rd;
        logic [6:0]  opcode;
    } i_fmt_t;
    typedef struct packed {
        logic [6:0] imm_hi;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] funct3;
        logic [4:0] imm_lo;
        logic [6:0] opcode;
    } s_fmt_t;
    typedef union packed {
        bus32_t raw;
        u_fmt_t u;
        i_fmt_t i;
        s_fmt_t s;
    } instr_fmt_t;
    function automatic bus32_t enc_u(logic [19:0] imm, logic [4:0] rd, logic [6:0] op);
        instr_fmt_t w;
        w.u = '{imm: imm, rd: rd, opcode: op};
        return w.raw;
    endfunction
    function automatic bus32_t enc_i(logic [11:0] imm, logic [4:0] rs1, logic [2:0] f3,
                                     logic [4:0] rd, logic [6:0] op);
        instr_fmt_t w;
        w.i = '{imm: imm, rs1: rs1, funct3: f3, rd: rd, opcode: op};
        return w.raw;
    endfunction
    function automatic bus32_t enc_s(logic [11:0] imm, logic [4:0] rs2, logic [4:0] rs1,
                                     logic [6:0] op);
        instr_fmt_t w;
        w.s = '{imm_hi: imm[11:5], rs2: rs2, rs1: rs1, funct3: F3_WORD, imm_lo: imm[4:0], opcode: op};
        return w.raw;
    endfunction
endpackage

// File: rtl/instr_encoder_imm_packer.sv
// imm_packer: combinational packing of one request into its instruction word(s) plus range error.
//   kind/funct3/rd/rs1/rs2/imm - request fields
//   word   - first (or only) encoded word
//   second - ADDI word of a two-word LI
//   two    - request expands into two words
//   err    - immediate out of range for the first word
module imm_packer
    import instr_encoder_pkg::*;
#(
    parameter int RANGE_CHECK = 1
) (
    input  logic [2:0]  kind,
    input  logic [2:0]  funct3,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    output logic [31:0] word,
    output logic [31:0] second,
    output logic        two,
    output logic        err
);
    enc_kind_t   k;
    logic [31:0] li_sum;
    logic [19:0] hi;
    logic [11:0] lo;
    logic        i_err, sh_err, raw_err;
    assign k      = enc_kind_t'(kind);
    // Rounding by 0x800 compensates for ADDI sign-extending its 12-bit immediate.
    assign li_sum = imm + 32'h800;
    assign hi     = li_sum[31:12];
    assign lo     = imm[11:0];
    // A 12-bit signed immediate fits when bits 31..11 are all copies of the sign.
    assign i_err  = !(&imm[31:11] || ~|imm[31:11]);
    // imm[10] selects SRAI; it is only meaningful for funct3 101.
    assign sh_err = |imm[31:11] || |imm[9:5] || (funct3 == 3'b001 && imm[10]);
    always_comb begin
        word    = NOP;
        second  = '0;
        two     = 1'b0;
        raw_err = 1'b0;
        case (k)
            ENC_LUI: begin
                word    = enc_u(imm[31:12], rd, OP_LUI);
                raw_err = |imm[11:0];
            end
            ENC_AUIPC: begin
                word    = enc_u(imm[31:12], rd, OP_AUIPC);
                raw_err = |imm[11:0];
            end
            ENC_ALU_I: begin
                word    = enc_i(imm[11:0], rs1, funct3, rd, OP_ALU_I);
                raw_err = funct3[1:0] == 2'b01 ? sh_err : i_err;
            end
            ENC_LW: begin
                word    = enc_i(imm[11:0], rs1, F3_WORD, rd, OP_LW);
                raw_err = i_err;
            end
            ENC_SW: begin
                word    = enc_s(imm[11:0], rs2, rs1, OP_SW);
                raw_err = i_err;
            end
            ENC_LI: begin
                word    = hi == '0 ? enc_i(lo, 5'd0, 3'd0, rd, OP_ALU_I) : enc_u(hi, rd, OP_LUI);
                second  = enc_i(lo, rd, 3'd0, rd, OP_ALU_I);
                two     = hi != '0 && lo != '0;
            end
            default: raw_err = 1'b1;
        endcase
    end
    assign err = (RANGE_CHECK != 0) && raw_err;
endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: encodes field-level requests into RV32I words on a registered valid/ready stream.
//   clk_i, rstn_i                     - clock, async active-low reset
//   req_valid_i/req_ready_o           - request handshake
//   req_kind_i..req_imm_i             - request fields
//   instr_valid_o/instr_ready_i       - output handshake
//   instr_o, instr_err_o, instr_last_o - encoded word, range error, last word of request
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int RANGE_CHECK = 1
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [2:0]  req_kind_i,
    input  logic [2:0]  req_funct3_i,
    input  logic [4:0]  req_rd_i,
    input  logic [4:0]  req_rs1_i,
    input  logic [4:0]  req_rs2_i,
    input  logic [31:0] req_imm_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o,
    output logic        instr_err_o,
    output logic        instr_last_o
);
    typedef enum logic {IDLE, LI_LO} state_t;
    state_t      state, state_n;
    bus32_t      pend, p_word, p_second, word_n;
    logic        p_two, p_err, out_free, accept, load, err_n, last_n;
    imm_packer #(.RANGE_CHECK(RANGE_CHECK)) u_pack (
        .kind   (req_kind_i),
        .funct3 (req_funct3_i),
        .rd     (req_rd_i),
        .rs1    (req_rs1_i),
        .rs2    (req_rs2_i),
        .imm    (req_imm_i),
        .word   (p_word),
        .second (p_second),
        .two    (p_two),
        .err    (p_err)
    );
    assign out_free    = !instr_valid_o || instr_ready_i;
    assign req_ready_o = out_free && state == IDLE;
    assign accept      = req_valid_i && req_ready_o;
    always_comb begin
        state_n = state;
        load    = accept;
        word_n  = p_word;
        err_n   = p_err;
        last_n  = !p_two;
        if (state == IDLE) begin
            state_n = accept && p_two ? LI_LO : IDLE;
        end else if (out_free) begin
            state_n = IDLE;
            load    = 1'b1;
            word_n  = pend;
            err_n   = 1'b0;
            last_n  = 1'b1;
        end
    end
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state         <= IDLE;
            instr_valid_o <= 1'b0;
            instr_o       <= '0;
            instr_err_o   <= 1'b0;
            instr_last_o  <= 1'b0;
            pend          <= '0;
        end else begin
            state <= state_n;
            if (load) begin
                instr_valid_o <= 1'b1;
                instr_o       <= word_n;
                instr_err_o   <= err_n;
                instr_last_o  <= last_n;
            end else if (instr_ready_i) begin
                instr_valid_o <= 1'b0;
            end
            if (accept) pend <= p_second;
        end
    end
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed and randomized checks of instr_encoder against an arithmetic reference model.
module tb_instr_encoder;
    logic        clk = 1'b0;
    logic        rstn;
    logic        req_valid, req_ready;
    logic [2:0]  req_kind, req_funct3;
    logic [4:0]  req_rd, req_rs1, req_rs2;
    logic [31:0] req_imm;
    logic        instr_valid, instr_ready;
    logic [31:0] instr;
    logic        instr_err, instr_last;
    int          vectors = 0;
    int          miscompares = 0;

    always #5 clk = ~clk;

    instr_encoder dut (
        .clk_i         (clk),
        .rstn_i        (rstn),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready),
        .req_kind_i    (req_kind),
        .req_funct3_i  (req_funct3),
        .req_rd_i      (req_rd),
        .req_rs1_i     (req_rs1),
        .req_rs2_i     (req_rs2),
        .req_imm_i     (req_imm),
        .instr_valid_o (instr_valid),
        .instr_ready_i (instr_ready),
        .instr_o       (instr),
        .instr_err_o   (instr_err),
        .instr_last_o  (instr_last)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: words built by shifting fields into place, ranges checked as signed integers.
    task automatic model(input logic [2:0] k, input logic [2:0] f3, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm,
                         output int n, output logic [31:0] w0, output logic [31:0] w1,
                         output logic e);
        int          si;
        logic [31:0] rdx, hi, lo;
        si  = $signed(imm);
        rdx = 32'(rd) << 7;
        n   = 1;
        w0  = 32'h13;
        w1  = 32'h0;
        e   = 1'b0;
        case (k)
            3'd0, 3'd1: begin
                w0 = (imm & 32'hFFFFF000) | rdx | (k == 3'd0 ? 32'h37 : 32'h17);
                e  = (imm & 32'hFFF) != 0;
            end
            3'd2: begin
                w0 = ((imm & 32'hFFF) << 20) | (32'(rs1) << 15) | (32'(f3) << 12) | rdx | 32'h13;
                if (f3 == 3'd1)      e = !(si >= 0 && si <= 31);
                else if (f3 == 3'd5) e = !((si >= 0 && si <= 31) || (si >= 1024 && si <= 1055));
                else                 e = si < -2048 || si > 2047;
            end
            3'd3: begin
                w0 = ((imm & 32'hFFF) << 20) | (32'(rs1) << 15) | 32'h2000 | rdx | 32'h03;
                e  = si < -2048 || si > 2047;
            end
            3'd4: begin
                w0 = (((imm >> 5) & 32'h7F) << 25) | (32'(rs2) << 20) | (32'(rs1) << 15)
                   | 32'h2000 | ((imm & 32'h1F) << 7) | 32'h23;
                e  = si < -2048 || si > 2047;
            end
            3'd5: begin
                hi = (imm + 32'd2048) >> 12;
                lo = imm & 32'hFFF;
                if (hi == 0) w0 = (lo << 20) | rdx | 32'h13;
                else begin
                    w0 = (hi << 12) | rdx | 32'h37;
                    if (lo != 0) begin
                        n  = 2;
                        w1 = (lo << 20) | (32'(rd) << 15) | rdx | 32'h13;
                    end
                end
            end
            default: e = 1'b1;
        endcase
    endtask

    task automatic run_req(input logic [2:0] k, input logic [2:0] f3, input logic [4:0] rd,
                           input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm);
        int          n;
        logic [31:0] w[2];
        logic        e;
        model(k, f3, rd, rs1, rs2, imm, n, w[0], w[1], e);
        @(negedge clk);
        req_kind = k; req_funct3 = f3; req_rd = rd; req_rs1 = rs1; req_rs2 = rs2; req_imm = imm;
        req_valid = 1'b1;
        instr_ready = 1'b1;
        chk("req_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("valid", 32'(instr_valid), 32'd1);
            chk($sformatf("word k=%0d imm=%h #%0d", k, imm, i), instr, w[i]);
            chk("err", 32'(instr_err), i == 0 ? 32'(e) : 32'd0);
            chk("last", 32'(instr_last), 32'(i == n - 1));
        end
        @(negedge clk);
        chk("idle_valid", 32'(instr_valid), 32'd0);
    endtask

    initial begin
        int          sel;
        logic [31:0] imm;
        rstn = 1'b0;
        req_valid = 1'b0; req_kind = '0; req_funct3 = '0;
        req_rd = '0; req_rs1 = '0; req_rs2 = '0; req_imm = '0;
        instr_ready = 1'b1;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_err", 32'(instr_err), 32'd0);
        chk("rst_last", 32'(instr_last), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd1);

        run_req(3'd5, 3'd0, 5'd5, 5'd0, 5'd0, 32'h12345678);
        run_req(3'd5, 3'd0, 5'd1, 5'd0, 5'd0, 32'hFFFFF800);
        run_req(3'd5, 3'd0, 5'd2, 5'd0, 5'd0, 32'h00001800);
        run_req(3'd5, 3'd0, 5'd9, 5'd0, 5'd0, 32'h00007000);
        run_req(3'd4, 3'd0, 5'd0, 5'd2, 5'd7, 32'hFFFFFFFC);
        run_req(3'd2, 3'd0, 5'd3, 5'd4, 5'd0, 32'd4096);
        run_req(3'd2, 3'd0, 5'd3, 5'd4, 5'd0, 32'd2047);
        run_req(3'd2, 3'd0, 5'd3, 5'd4, 5'd0, 32'hFFFFF800);
        run_req(3'd2, 3'd0, 5'd3, 5'd4, 5'd0, 32'hFFFFF7FF);
        run_req(3'd2, 3'd5, 5'd6, 5'd7, 5'd0, 32'd1031);
        run_req(3'd2, 3'd1, 5'd6, 5'd7, 5'd0, 32'd1031);
        run_req(3'd0, 3'd0, 5'd8, 5'd0, 5'd0, 32'hABCDE000);
        run_req(3'd1, 3'd0, 5'd8, 5'd0, 5'd0, 32'hABCDE001);
        run_req(3'd3, 3'd0, 5'd10, 5'd11, 5'd0, 32'h00000010);
        run_req(3'd6, 3'd0, 5'd1, 5'd1, 5'd1, 32'h0);

        // Stalled two-word LI: LUI must hold, no new request accepted.
        @(negedge clk);
        req_kind = 3'd5; req_rd = 5'd5; req_imm = 32'h12345678;
        req_valid = 1'b1;
        instr_ready = 1'b0;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_valid", 32'(instr_valid), 32'd1);
            chk("stall_lui", instr, 32'h123452B7);
            chk("stall_last", 32'(instr_last), 32'd0);
            chk("stall_req_ready", 32'(req_ready), 32'd0);
        end
        instr_ready = 1'b1;
        @(negedge clk);
        chk("stall_addi", instr, 32'h67828293);
        chk("stall_addi_last", 32'(instr_last), 32'd1);
        @(negedge clk);
        chk("stall_drained", 32'(instr_valid), 32'd0);

        // Reset while the ADDI is pending.
        req_kind = 3'd5; req_rd = 5'd3; req_imm = 32'h12345678;
        req_valid = 1'b1;
        instr_ready = 1'b0;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_valid", 32'(instr_valid), 32'd1);
        rstn = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(instr_valid), 32'd0);
        chk("mid_rst_instr", instr, 32'd0);
        chk("mid_rst_last", 32'(instr_last), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        instr_ready = 1'b1;
        chk("post_rst_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        chk("no_stale_addi", 32'(instr_valid), 32'd0);
        run_req(3'd2, 3'd0, 5'd12, 5'd13, 5'd0, 32'h00000123);

        for (int t = 0; t < 40; t++) begin
            sel = $urandom_range(0, 3);
            imm = sel == 0 ? 32'($urandom_range(0, 4095)) - 32'd2048 :
                  sel == 1 ? 32'($urandom) :
                  sel == 2 ? 32'($urandom) & 32'hFFFFF000 : 32'($urandom_range(0, 1100));
            run_req(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)),
                    5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), imm);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
